solver_dispatch_ctrl: RTL and testbench
=======================================

Name: solver_dispatch_ctrl

Overview:
- Scheduler that walks the divisions ROM and hands one entry at a time to a pool of NUM_LANES solver lanes.
- Collects each lane's partial sum into a 64-bit total and asserts done once every entry has been issued and every result returned.
- Sits between the divisions ROM and the replicated solver lanes, replacing the single-lane sequencing inside solver_v2.

Parameters:
- ENTRY_COUNT, 468, number of ROM entries to dispatch (0 allowed).
- ADDR_W, 9, ROM address width; must satisfy 2^ADDR_W >= ENTRY_COUNT.
- ENTRY_W, 128, width of one ROM entry.
- NUM_LANES, 4, number of solver lanes (1..16).
- SUM_W, 64, width of lane results and of total_sum.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when the block is IDLE or DONE.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  ENTRY_W  ROM data, valid one cycle after rom_en.
- lane_valid  out  NUM_LANES  one-hot offer of lane_data to a lane.
- lane_ready  in  NUM_LANES  lane can accept an entry; must not depend on lane_valid.
- lane_data  out  ENTRY_W  staged entry, broadcast to all lanes.
- res_valid  in  NUM_LANES  per-lane result strobe, one cycle per accepted entry.
- res_data  in  NUM_LANES*SUM_W  per-lane results; lane i occupies bits [i*SUM_W +: SUM_W].
- busy  out  1  run in progress.
- done  out  1  high in DONE until the next start.
- total_sum  out  SUM_W  accumulated sum.
- overflow  out  1  sticky; accumulator wrapped.
- proto_err  out  1  sticky; res_valid seen with no entries outstanding.

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0 and state is IDLE.
  - The index, outstanding count and rr_ptr are 0.
- States: IDLE, FETCH, WAIT, DISPATCH, DRAIN, DONE.
- IDLE/DONE:
  - On start, clear total_sum, overflow, proto_err, the index and the outstanding count.
  - If ENTRY_COUNT==0, go to DONE the next cycle; otherwise go to FETCH.
  - busy=1 in every state except IDLE and DONE.
- FETCH: rom_en=1 and rom_addr=index for exactly one cycle, then WAIT.
- WAIT: capture rom_data into the staging register at the end of the cycle, then DISPATCH.
- DISPATCH:
  - lane_data is held stable from the staging register.
  - Grant the first lane i with lane_ready[i]=1, scanning upward from rr_ptr with wrap-around.
  - lane_valid is one-hot on the granted lane; it is 0 if no lane is ready.
  - A transfer occurs when valid and ready are both high on that lane. On transfer:
    - rr_ptr = grant+1 mod NUM_LANES, and index and outstanding are incremented.
    - Go to FETCH if index+1 < ENTRY_COUNT, else DRAIN.
  - With no ready lane, stay in DISPATCH indefinitely; this is not an error.
- Throughput: at most one entry per 3 cycles.
- DRAIN: wait until outstanding==0, then DONE. done asserts in the first DONE cycle.
- Results, accepted in every non-IDLE state:
  - Each cycle, every lane with res_valid is accepted.
  - total_sum += sum of the valid res_data words, using one combined adder. Arithmetic is modulo 2^SUM_W.
  - overflow is set if any carry out of bit SUM_W-1 occurs.
  - outstanding -= popcount(res_valid). When dispatch and results happen in the same cycle, both are applied.
  - If popcount exceeds outstanding (including that cycle's dispatch), set proto_err and saturate outstanding at 0.
- start while busy is ignored.
- res_valid in IDLE or DONE is ignored: no accumulation and no flag.
- Reset mid-run aborts immediately to IDLE with all outputs 0. The ROM and lanes are not otherwise notified.
- Latency from a start edge to the first rom_en is 1 cycle. A single-entry run with a lane that is ready and answers immediately reaches done after the final result plus 1 cycle.

Test Plan:
- ENTRY_COUNT=4, NUM_LANES=1, lane always ready, each result returned 2 cycles after accept with values 10,20,30,40 -> total_sum=100, done=1, rom_addr sequence 0,1,2,3, overflow=0, proto_err=0.
- NUM_LANES=4, all lanes always ready, ENTRY_COUNT=6 -> grants go to lanes 0,1,2,3,0,1. All four lanes strobe res_valid in the same cycle with 1,2,3,4 -> sum increases by 10 in one cycle.
- Backpressure: all lane_ready=0 for 10 cycles while in DISPATCH -> lane_data stable and busy=1. Raising lane_ready[2] only -> transfer to lane 2.
- Overflow: two results of 0xFFFFFFFFFFFFFFFF and 2 -> total_sum=1, overflow=1. A spurious res_valid in DRAIN with outstanding=0 -> proto_err=1.
- Reset and restart:
  - Deassert rst_n mid-DISPATCH -> all outputs 0 at once.
  - A subsequent start reruns from rom_addr 0.
  - A start during busy is ignored.
  - ENTRY_COUNT=0 -> done one cycle after start.
- Full run: divisions_v2.hex, ENTRY_COUNT=468, 4 solver lanes -> total_sum=32976912643, proto_err=0.

Source files
------------

// File: rtl/solver_dispatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// solver_dispatch_ctrl : round-robin ROM-to-lane dispatcher with 64-bit result accumulation
// Revision 1.0
// ---------------------------------------------------------------------------
module solver_dispatch_ctrl #(
   parameter int ENTRY_COUNT = 468,
   parameter int ADDR_W      = 9,
   parameter int ENTRY_W     = 128,
   parameter int NUM_LANES   = 4,
   parameter int SUM_W       = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       rom_en,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [ENTRY_W-1:0]         rom_data,
   output logic [NUM_LANES-1:0]       lane_valid,
   input  logic [NUM_LANES-1:0]       lane_ready,
   output logic [ENTRY_W-1:0]         lane_data,
   input  logic [NUM_LANES-1:0]       res_valid,
   input  logic [NUM_LANES*SUM_W-1:0] res_data,
   output logic                       busy,
   output logic                       done,
   output logic [SUM_W-1:0]           total_sum,
   output logic                       overflow,
   output logic                       proto_err
);

   localparam int IDX_W  = ADDR_W + 1;
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_W  = $clog2(NUM_LANES + 1);
   localparam int OUT_W  = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 1;
   localparam int ACC_W  = SUM_W + 5;
   localparam logic [IDX_W-1:0]  C_ENTRY_COUNT = IDX_W'(ENTRY_COUNT);
   localparam logic [LANE_W:0]   C_LANES       = (LANE_W+1)'(NUM_LANES);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_WAIT     = 3'd2,
      S_DISPATCH = 3'd3,
      S_DRAIN    = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     index;
   logic [IDX_W-1:0]     outstanding;
   logic [LANE_W-1:0]    rr_ptr;
   logic [ENTRY_W-1:0]   stage;

   logic [2*NUM_LANES-1:0] ready_dbl;
   logic [NUM_LANES-1:0]   ready_rot;
   logic                   grant_found;
   logic [LANE_W:0]        grant_wide;
   logic [LANE_W:0]        rr_next_wide;
   logic                   xfer;
   logic                   res_active;
   logic [ACC_W-1:0]       acc_sum;
   logic [CNT_W-1:0]       pop;
   logic [OUT_W-1:0]       out_plus;
   logic [OUT_W-1:0]       pop_ext;
   logic                   underflow;
   logic [OUT_W-1:0]       out_next;
   logic [IDX_W-1:0]       index_inc;

   // Rotating the ready vector by rr_ptr turns the wrap-around search into a
   // plain lowest-set-bit scan.
   assign ready_dbl = {lane_ready, lane_ready} >> rr_ptr;
   assign ready_rot = ready_dbl[NUM_LANES-1:0];

   always_comb begin
      grant_found  = 1'b0;
      grant_wide   = '0;
      rr_next_wide = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!grant_found && ready_rot[k]) begin
            grant_found = 1'b1;
            grant_wide  = {1'b0, rr_ptr} + (LANE_W+1)'(k);
         end
      end
      if (grant_wide >= C_LANES) grant_wide = grant_wide - C_LANES;
      rr_next_wide = grant_wide + 1'b1;
      if (rr_next_wide == C_LANES) rr_next_wide = '0;
   end

   assign xfer       = (state == S_DISPATCH) && grant_found;
   assign lane_valid = xfer ? (NUM_LANES'(1) << grant_wide[LANE_W-1:0]) : '0;
   assign lane_data  = stage;
   assign res_active = (state != S_IDLE) && (state != S_DONE);
   assign index_inc  = index + 1'b1;

   always_comb begin
      acc_sum = ACC_W'(total_sum);
      pop     = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (res_valid[k]) begin
            acc_sum = acc_sum + ACC_W'(res_data[k*SUM_W +: SUM_W]);
            pop     = pop + 1'b1;
         end
      end
   end

   assign out_plus  = OUT_W'(outstanding) + OUT_W'(xfer);
   assign pop_ext   = OUT_W'(pop);
   assign underflow = pop_ext > out_plus;
   assign out_next  = underflow ? '0 : (out_plus - pop_ext);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         index       <= '0;
         outstanding <= '0;
         rr_ptr      <= '0;
         stage       <= '0;
         rom_en      <= 1'b0;
         rom_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         total_sum   <= '0;
         overflow    <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         rom_en <= 1'b0;
         if (res_active) begin
            total_sum   <= acc_sum[SUM_W-1:0];
            outstanding <= out_next[IDX_W-1:0];
            if (acc_sum[ACC_W-1:SUM_W] != '0) overflow  <= 1'b1;
            if (underflow)                    proto_err <= 1'b1;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  total_sum   <= '0;
                  overflow    <= 1'b0;
                  proto_err   <= 1'b0;
                  index       <= '0;
                  outstanding <= '0;
                  if (ENTRY_COUNT == 0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_FETCH;
                     done     <= 1'b0;
                     busy     <= 1'b1;
                     rom_en   <= 1'b1;
                     rom_addr <= '0;
                  end
               end
            end
            S_FETCH: state <= S_WAIT;
            S_WAIT: begin
               stage <= rom_data;
               state <= S_DISPATCH;
            end
            S_DISPATCH: begin
               if (xfer) begin
                  rr_ptr <= rr_next_wide[LANE_W-1:0];
                  index  <= index_inc;
                  if (index_inc < C_ENTRY_COUNT) begin
                     state    <= S_FETCH;
                     rom_en   <= 1'b1;
                     rom_addr <= index_inc[ADDR_W-1:0];
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (out_next == '0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_solver_dispatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_solver_dispatch_ctrl : randomized lanes/ROM against a transaction-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_solver_dispatch_ctrl;

   localparam int EC = 12;
   localparam int AW = 4;
   localparam int EW = 32;
   localparam int NL = 4;
   localparam int SW = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              rom_en;
   logic [AW-1:0]     rom_addr;
   logic [EW-1:0]     rom_data = '0;
   logic [NL-1:0]     lane_valid;
   logic [NL-1:0]     lane_ready = '0;
   logic [EW-1:0]     lane_data;
   logic [NL-1:0]     res_valid = '0;
   logic [NL*SW-1:0]  res_data = '0;
   logic              busy, done, overflow, proto_err;
   logic [SW-1:0]     total_sum;

   logic              start_z = 1'b0;
   logic              rom_en_z;
   logic [0:0]        rom_addr_z;
   logic [7:0]        rom_data_z = '0;
   logic [0:0]        lane_valid_z;
   logic [0:0]        lane_ready_z = '0;
   logic [7:0]        lane_data_z;
   logic [0:0]        res_valid_z = '0;
   logic [7:0]        res_data_z = '0;
   logic              busy_z, done_z, overflow_z, proto_err_z;
   logic [7:0]        total_sum_z;

   always #5 clk = ~clk;

   solver_dispatch_ctrl #(
      .ENTRY_COUNT(EC), .ADDR_W(AW), .ENTRY_W(EW), .NUM_LANES(NL), .SUM_W(SW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_data(lane_data),
      .res_valid(res_valid), .res_data(res_data),
      .busy(busy), .done(done), .total_sum(total_sum),
      .overflow(overflow), .proto_err(proto_err)
   );

   solver_dispatch_ctrl #(
      .ENTRY_COUNT(0), .ADDR_W(1), .ENTRY_W(8), .NUM_LANES(1), .SUM_W(8)
   ) u_dut_zero (
      .clk(clk), .rst_n(rst_n), .start(start_z),
      .rom_en(rom_en_z), .rom_addr(rom_addr_z), .rom_data(rom_data_z),
      .lane_valid(lane_valid_z), .lane_ready(lane_ready_z), .lane_data(lane_data_z),
      .res_valid(res_valid_z), .res_data(res_data_z),
      .busy(busy_z), .done(done_z), .total_sum(total_sum_z),
      .overflow(overflow_z), .proto_err(proto_err_z)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          due;
      int          lane;
      logic [SW-1:0] val;
   } res_t;

   logic [EW-1:0] rom [EC];
   res_t          pend[$];
   int            last_due [NL];
   logic [127:0]  exp_sum;
   int            exp_next, exp_rr, n_fetch, n_xfer, last_xfer_cyc, last_res_cyc, cyc;
   int            fetch_addr, ready_pct;
   bit            exp_perr, fetch_pending, use_fix, big_mode, inject_spur;
   logic [NL-1:0] ready_fix;

   // Expected grant: first ready lane at or after the pointer, wrapping.
   function automatic logic [NL-1:0] expect_grant(input logic [NL-1:0] rdy, input int ptr);
      int l;
      for (int k = 0; k < NL; k++) begin
         l = (ptr + k) % NL;
         if (rdy[l]) return NL'(1) << l;
      end
      return '0;
   endfunction

   function automatic logic [SW-1:0] make_result();
      if (big_mode && $urandom_range(1) == 1)
         return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(3));
      else if (big_mode)
         return {$urandom, $urandom};
      return 64'($urandom);
   endfunction

   task automatic step();
      logic [NL-1:0]    rv;
      logic [NL*SW-1:0] rd;
      res_t             keep[$];
      logic [SW-1:0]    v;
      int               l, d, due;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      rom_data = fetch_pending ? rom[fetch_addr] : EW'($urandom);
      fetch_pending = 1'b0;
      rv = '0;
      for (int k = 0; k < NL; k++) rd[k*SW +: SW] = {$urandom, $urandom};
      foreach (pend[i]) begin
         if (pend[i].due == cyc) begin
            rv[pend[i].lane] = 1'b1;
            rd[pend[i].lane*SW +: SW] = pend[i].val;
            exp_sum += 128'(pend[i].val);
            last_res_cyc = cyc;
         end else begin
            keep.push_back(pend[i]);
         end
      end
      pend = keep;
      if (inject_spur) begin
         v = make_result();
         rv[0] = 1'b1;
         rd[0 +: SW] = v;
         exp_sum += 128'(v);
         exp_perr = 1'b1;
         inject_spur = 1'b0;
      end
      res_valid = rv;
      res_data  = rd;
      if (use_fix) lane_ready = ready_fix;
      else for (int k = 0; k < NL; k++) lane_ready[k] = ($urandom_range(99) < ready_pct);
      #1;
      if (rom_en) begin
         chk("rom_addr", 128'(rom_addr), 128'(n_fetch));
         fetch_pending = 1'b1;
         fetch_addr = n_fetch % EC;
         n_fetch++;
      end
      if (lane_valid != '0) begin
         chk("grant", 128'(lane_valid), 128'(expect_grant(lane_ready, exp_rr)));
         chk("lane_data", 128'(lane_data), 128'(rom[exp_next % EC]));
         if (n_xfer > 0) chk("xfer_gap", 128'((cyc - last_xfer_cyc) >= 3), 128'(1));
         if ((lane_valid & lane_ready) != '0) begin
            l = 0;
            for (int k = 0; k < NL; k++) if (lane_valid[k] & lane_ready[k]) l = k;
            d   = $urandom_range(1, 6);
            due = cyc + d;
            if (due <= last_due[l]) due = last_due[l] + 1;
            last_due[l] = due;
            pend.push_back('{due: due, lane: l, val: make_result()});
            exp_rr = (l + 1) % NL;
            exp_next++;
            n_xfer++;
            last_xfer_cyc = cyc;
         end
      end
   endtask

   task automatic begin_run(input int pct, input bit big, input bit spur);
      exp_sum = '0; exp_next = 0; n_fetch = 0; n_xfer = 0; exp_perr = 1'b0;
      big_mode = big; ready_pct = pct; use_fix = 1'b0; inject_spur = spur;
      start = 1'b1;
      step();
   endtask

   task automatic run(input int pct, input bit big, input bit spur);
      begin_run(pct, big, spur);
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_rom_en", 128'(rom_en), 128'(1));
      for (int i = 0; i < 4000 && !done; i++) begin
         if (i == 5) start = 1'b1;
         step();
      end
      chk("done", 128'(done), 128'(1));
      chk("busy_at_done", 128'(busy), 128'(0));
      chk("xfer_count", 128'(n_xfer), 128'(EC));
      chk("results_back", 128'(pend.size()), 128'(0));
      chk("done_latency", 128'(cyc - last_res_cyc), 128'(1));
      chk("total_sum", 128'(total_sum), 128'(exp_sum[SW-1:0]));
      chk("overflow", 128'(overflow), 128'(exp_sum[127:SW] != '0));
      chk("proto_err", 128'(proto_err), 128'(exp_perr));
   endtask

   task automatic bp_reset();
      exp_sum = '0; exp_next = 0; n_fetch = 0; n_xfer = 0; exp_perr = 1'b0;
      big_mode = 1'b0; use_fix = 1'b1; ready_fix = '0; inject_spur = 1'b0;
      start = 1'b1;
      step(); step(); step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 128'(lane_valid), 128'(0));
         chk("bp_busy", 128'(busy), 128'(1));
         chk("bp_data", 128'(lane_data), 128'(rom[0]));
         step();
      end
      ready_fix = 4'b0100;
      step();
      chk("bp_grant2", 128'(lane_valid), 128'(4'b0100));
      ready_fix = '0;
      step(); step(); step();
      chk("bp_data2", 128'(lane_data), 128'(rom[1]));
      #1 rst_n = 1'b0;
      #1;
      chk("rst_flags", 128'({rom_en, busy, done, overflow, proto_err}), 128'(0));
      chk("rst_addr", 128'(rom_addr), 128'(0));
      chk("rst_valid", 128'(lane_valid), 128'(0));
      chk("rst_data", 128'(lane_data), 128'(0));
      chk("rst_sum", 128'(total_sum), 128'(0));
      res_valid = '0; lane_ready = '0; use_fix = 1'b0;
      pend.delete();
      fetch_pending = 1'b0;
      exp_rr = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < EC; i++) rom[i] = $urandom;
      for (int k = 0; k < NL; k++) last_due[k] = 0;
      exp_rr = 0; cyc = 0; fetch_pending = 1'b0; use_fix = 1'b0; inject_spur = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", 128'({rom_en, busy, done, overflow, proto_err}), 128'(0));
      chk("reset_sum", 128'(total_sum), 128'(0));
      chk("reset_valid", 128'(lane_valid), 128'(0));
      chk("reset_data", 128'(lane_data), 128'(0));
      chk("reset_zero_done", 128'(done_z), 128'(0));
      rst_n = 1'b1;

      start_z = 1'b1;
      @(posedge clk);
      #1 start_z = 1'b0;
      chk("zero_done", 128'(done_z), 128'(1));
      chk("zero_flags", 128'({busy_z, rom_en_z, lane_valid_z, overflow_z, proto_err_z}), 128'(0));
      chk("zero_out", 128'({rom_addr_z, lane_data_z, total_sum_z}), 128'(0));

      run(100, 1'b0, 1'b0);
      // Strobes while DONE must neither accumulate nor flag.
      res_valid = '1;
      for (int k = 0; k < NL; k++) res_data[k*SW +: SW] = {$urandom, $urandom};
      @(posedge clk);
      #1 res_valid = '0;
      chk("done_ignore_sum", 128'(total_sum), 128'(exp_sum[SW-1:0]));
      chk("done_ignore_err", 128'(proto_err), 128'(0));

      run(60, 1'b0, 1'b1);
      run(40, 1'b1, 1'b0);
      bp_reset();
      run(70, 1'b1, 1'b1);
      run(30, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
